// File: rtl/rwt_sample_pkg.sv
// Shared types and helpers for the transmit sample unpacker.
package rwt_sample_pkg;

  localparam int SAMPLE_W = 32;
  localparam int WORD_W   = 64;

  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DUAL    = 2'd0,
    SINGLE0 = 2'd1,
    SINGLE1 = 2'd2,
    NONE    = 2'd3
  } mode_t;

  // Channel enables are per 16-bit lane; any enabled lane enables its channel.
  function automatic mode_t decode_mode(input logic [3:0] enables);
    logic  ch0;
    logic  ch1;
    mode_t mode;
    ch0 = |enables[1:0];
    ch1 = |enables[3:2];
    case ({ch1, ch0})
      2'b11:   mode = DUAL;
      2'b01:   mode = SINGLE0;
      2'b10:   mode = SINGLE1;
      default: mode = NONE;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/rwt_axis_skid.sv
// Registered AXI-Stream skid slice: output register plus one overflow entry,
// so ready is purely registered while sustaining one transfer per cycle.
module rwt_axis_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         out_valid_r, out_valid_nxt_s;
  logic [W-1:0] out_data_r, out_data_nxt_s;
  logic         skid_valid_r, skid_valid_nxt_s;
  logic [W-1:0] skid_data_r, skid_data_nxt_s;
  logic         ready_r, ready_nxt_s;
  logic         push_s;
  logic         load_s;

  assign s_ready = ready_r;
  assign m_valid = out_valid_r;
  assign m_data  = out_data_r;

  // Next-state: refill the output register from the skid entry first, then from the input.
  always_comb begin
    push_s           = s_valid & ready_r;
    load_s           = ~out_valid_r | m_ready;
    out_valid_nxt_s  = out_valid_r;
    out_data_nxt_s   = out_data_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_data_nxt_s  = skid_data_r;
    if (load_s) begin
      if (skid_valid_r) begin
        out_valid_nxt_s  = 1'b1;
        out_data_nxt_s   = skid_data_r;
        skid_valid_nxt_s = 1'b0;
      end else begin
        out_valid_nxt_s = push_s;
        out_data_nxt_s  = push_s ? s_data : out_data_r;
      end
    end else begin
      skid_valid_nxt_s = skid_valid_r | push_s;
      skid_data_nxt_s  = push_s ? s_data : skid_data_r;
    end
    ready_nxt_s = ~skid_valid_nxt_s;
  end

  // Slice state registers; ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {W{1'b0}};
      ready_r      <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      out_data_r   <= out_data_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
      ready_r      <= ready_nxt_s;
    end
  end

endmodule

// File: rtl/rwt_sample_unpack.sv
// Unpacks dense 64-bit sample words into per-channel 32-bit slots.
// Define RWT_SAMPLE_UNPACK_REPLICATE_EN to copy the sample into the disabled slot.
module rwt_sample_unpack
  import rwt_sample_pkg::*;
#(
  parameter int UWIDTH = 1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [3:0]        enables,
  output logic              s_axi_ready,
  input  logic              s_axi_valid,
  input  logic [63:0]       s_axi_data,
  input  logic [UWIDTH-1:0] s_axi_user,
  input  logic              s_axi_last,
  input  logic              m_axi_ready,
  output logic              m_axi_valid,
  output logic [63:0]       m_axi_data,
  output logic [UWIDTH-1:0] m_axi_user,
  output logic              m_axi_last
);

  localparam int SL_W = WORD_W + 1 + UWIDTH;

  logic                sl_valid_s;
  logic                sl_ready_s;
  logic [SL_W-1:0]     sl_word_s;
  logic [WORD_W-1:0]   sl_data_s;
  logic                sl_last_s;
  logic [UWIDTH-1:0]   sl_user_s;

  state_t              state_r, state_nxt_s;
  mode_t               mode_r, mode_nxt_s, dec_mode_s;
  logic [SAMPLE_W-1:0] pend_data_r, pend_data_nxt_s;
  logic                pend_last_r, pend_last_nxt_s;
  logic [UWIDTH-1:0]   pend_user_r, pend_user_nxt_s;
  logic                m_valid_r, m_valid_nxt_s;
  logic [WORD_W-1:0]   m_data_r, m_data_nxt_s;
  logic                m_last_r, m_last_nxt_s;
  logic [UWIDTH-1:0]   m_user_r, m_user_nxt_s;
  logic                adv_s;

  function automatic logic [WORD_W-1:0] place_sample(input logic [SAMPLE_W-1:0] smp,
                                                     input mode_t mode);
    logic [SAMPLE_W-1:0] fill;
    logic [WORD_W-1:0]   word;
`ifdef RWT_SAMPLE_UNPACK_REPLICATE_EN
    fill = smp;
`else
    fill = {SAMPLE_W{1'b0}};
`endif
    case (mode)
      SINGLE0: word = {fill, smp};
      SINGLE1: word = {smp, fill};
      default: word = {fill, smp};
    endcase
    return word;
  endfunction

  rwt_axis_skid #(
    .W (SL_W)
  ) u_in_slice (
    .clk     (clk),
    .aresetn (aresetn),
    .s_valid (s_axi_valid),
    .s_ready (s_axi_ready),
    .s_data  ({s_axi_user, s_axi_last, s_axi_data}),
    .m_valid (sl_valid_s),
    .m_ready (sl_ready_s),
    .m_data  (sl_word_s)
  );

  assign sl_data_s   = sl_word_s[WORD_W-1:0];
  assign sl_last_s   = sl_word_s[WORD_W];
  assign sl_user_s   = sl_word_s[WORD_W+1 +: UWIDTH];
  assign adv_s       = ~m_valid_r | m_axi_ready;
  assign dec_mode_s  = decode_mode(enables);

  assign m_axi_valid = m_valid_r;
  assign m_axi_data  = m_data_r;
  assign m_axi_user  = m_user_r;
  assign m_axi_last  = m_last_r;

  // Unpack FSM: the slice is only popped in EMPTY, so a split word never loses its second half.
  always_comb begin
    state_nxt_s     = state_r;
    mode_nxt_s      = mode_r;
    pend_data_nxt_s = pend_data_r;
    pend_last_nxt_s = pend_last_r;
    pend_user_nxt_s = pend_user_r;
    m_valid_nxt_s   = m_valid_r;
    m_data_nxt_s    = m_data_r;
    m_last_nxt_s    = m_last_r;
    m_user_nxt_s    = m_user_r;
    sl_ready_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        sl_ready_s = adv_s;
        if (adv_s) begin
          m_valid_nxt_s = 1'b0;
          if (sl_valid_s) begin
            mode_nxt_s = dec_mode_s;
            case (dec_mode_s)
              DUAL: begin
                m_valid_nxt_s = 1'b1;
                m_data_nxt_s  = sl_data_s;
                m_last_nxt_s  = sl_last_s;
                m_user_nxt_s  = sl_user_s;
              end
              SINGLE0, SINGLE1: begin
                m_valid_nxt_s   = 1'b1;
                m_data_nxt_s    = place_sample(sl_data_s[63:32], dec_mode_s);
                m_last_nxt_s    = 1'b0;
                m_user_nxt_s    = sl_user_s;
                pend_data_nxt_s = sl_data_s[31:0];
                pend_last_nxt_s = sl_last_s;
                pend_user_nxt_s = sl_user_s;
                state_nxt_s     = PENDING;
              end
              default: begin
                m_valid_nxt_s = 1'b0;
              end
            endcase
          end else begin
            m_valid_nxt_s = 1'b0;
          end
        end else begin
          m_valid_nxt_s = m_valid_r;
        end
      end
      PENDING: begin
        if (adv_s) begin
          m_valid_nxt_s = 1'b1;
          m_data_nxt_s  = place_sample(pend_data_r, mode_r);
          m_last_nxt_s  = pend_last_r;
          m_user_nxt_s  = pend_user_r;
          state_nxt_s   = EMPTY;
        end else begin
          state_nxt_s = PENDING;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // State, pending half and output beat registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= EMPTY;
      mode_r      <= DUAL;
      pend_data_r <= {SAMPLE_W{1'b0}};
      pend_last_r <= 1'b0;
      pend_user_r <= {UWIDTH{1'b0}};
      m_valid_r   <= 1'b0;
      m_data_r    <= {WORD_W{1'b0}};
      m_last_r    <= 1'b0;
      m_user_r    <= {UWIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      mode_r      <= mode_nxt_s;
      pend_data_r <= pend_data_nxt_s;
      pend_last_r <= pend_last_nxt_s;
      pend_user_r <= pend_user_nxt_s;
      m_valid_r   <= m_valid_nxt_s;
      m_data_r    <= m_data_nxt_s;
      m_last_r    <= m_last_nxt_s;
      m_user_r    <= m_user_nxt_s;
    end
  end

endmodule

// File: tb/tb_rwt_sample_unpack.sv
// Scoreboard bench for rwt_sample_unpack; follows RWT_SAMPLE_UNPACK_REPLICATE_EN if defined.
module tb_rwt_sample_unpack;

  localparam int UW = 2;
  localparam int BW = 64 + 1 + UW;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [3:0]    enables = 4'h0;
  logic          s_axi_ready;
  logic          s_axi_valid = 1'b0;
  logic [63:0]   s_axi_data = 64'd0;
  logic [UW-1:0] s_axi_user = '0;
  logic          s_axi_last = 1'b0;
  logic          m_axi_ready = 1'b0;
  logic          m_axi_valid;
  logic [63:0]   m_axi_data;
  logic [UW-1:0] m_axi_user;
  logic          m_axi_last;

  int            chk_cnt = 0;
  int            pass_cnt = 0;
  int            ready_low_cnt = 0;
  logic          valid_seen = 1'b0;
  logic [BW-1:0] exp_q[$];
  logic          stall_q = 1'b0;
  logic [BW-1:0] stall_beat;
  logic [BW-1:0] mon_obs;
  logic [BW-1:0] mon_exp;

  rwt_sample_unpack #(.UWIDTH(UW)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .enables     (enables),
    .s_axi_ready (s_axi_ready),
    .s_axi_valid (s_axi_valid),
    .s_axi_data  (s_axi_data),
    .s_axi_user  (s_axi_user),
    .s_axi_last  (s_axi_last),
    .m_axi_ready (m_axi_ready),
    .m_axi_valid (m_axi_valid),
    .m_axi_data  (m_axi_data),
    .m_axi_user  (m_axi_user),
    .m_axi_last  (m_axi_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill_of(input logic [31:0] smp);
`ifdef RWT_SAMPLE_UNPACK_REPLICATE_EN
    return smp;
`else
    return 32'd0 & smp;
`endif
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic l, input logic [UW-1:0] u);
    logic c0, c1;
    c0 = |enables[1:0];
    c1 = |enables[3:2];
    if (c0 && c1) begin
      exp_q.push_back({u, l, d});
    end else if (c0) begin
      exp_q.push_back({u, 1'b0, fill_of(d[63:32]), d[63:32]});
      exp_q.push_back({u, l, fill_of(d[31:0]), d[31:0]});
    end else if (c1) begin
      exp_q.push_back({u, 1'b0, d[63:32], fill_of(d[63:32])});
      exp_q.push_back({u, l, d[31:0], fill_of(d[31:0])});
    end
  endtask

  // Output monitor: scoreboard pop on handshake, hold check while stalled.
  always @(negedge clk) begin
    if (!aresetn) begin
      stall_q = 1'b0;
    end else begin
      mon_obs = {m_axi_user, m_axi_last, m_axi_data};
      if (m_axi_valid) valid_seen = 1'b1;
      if (stall_q) begin
        chk_cnt++;
        if (m_axi_valid !== 1'b1 || mon_obs !== stall_beat)
          $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                   m_axi_valid, mon_obs, stall_beat);
        else pass_cnt++;
      end
      if (m_axi_valid && m_axi_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_beat: got %h, required no beat", mon_obs);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_obs !== mon_exp)
            $display("FAIL beat: got %h, required %h", mon_obs, mon_exp);
          else pass_cnt++;
        end
      end
      stall_q    = m_axi_valid & ~m_axi_ready;
      stall_beat = mon_obs;
    end
  end

  task automatic send_word(input logic [63:0] d, input logic l, input logic [UW-1:0] u);
    int   n;
    logic rdy;
    logic acc;
    s_axi_valid = 1'b1;
    s_axi_data  = d;
    s_axi_last  = l;
    s_axi_user  = u;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      rdy = s_axi_ready;
      if (!rdy) ready_low_cnt++;
      @(posedge clk);
      #1;
      acc = rdy;
      n++;
    end
    s_axi_valid = 1'b0;
    chk_cnt++;
    if (!acc) $display("FAIL send_timeout: got no accept after %0d cycles, required accept", n);
    else begin
      pass_cnt++;
      push_exp(d, l, u);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axi_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++;
    if ({m_axi_valid, m_axi_last, m_axi_user, m_axi_data, s_axi_ready} !== {BW+1{1'b0}})
      $display("FAIL reset_vals: got v=%b l=%b u=%h d=%h r=%b, required all 0",
               m_axi_valid, m_axi_last, m_axi_user, m_axi_data, s_axi_ready);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (s_axi_ready !== 1'b1) $display("FAIL ready_after_reset: got %b, required 1", s_axi_ready);
    else pass_cnt++;
  endtask

  task automatic test_dual();
    enables     = 4'hF;
    m_axi_ready = 1'b1;
    chk_cnt++;
    if (s_axi_ready !== 1'b1) $display("FAIL dual_ready: got %b, required 1", s_axi_ready);
    else pass_cnt++;
    s_axi_valid = 1'b1;
    s_axi_data  = 64'h11112222_33334444;
    s_axi_last  = 1'b0;
    s_axi_user  = 2'd1;
    @(posedge clk);
    #1;
    push_exp(64'h11112222_33334444, 1'b0, 2'd1);
    chk_cnt++;
    if (m_axi_valid !== 1'b0) $display("FAIL dual_lat_early: got valid %b, required 0", m_axi_valid);
    else pass_cnt++;
    s_axi_data = 64'h55556666_77778888;
    s_axi_last = 1'b1;
    s_axi_user = 2'd2;
    @(posedge clk);
    #1;
    push_exp(64'h55556666_77778888, 1'b1, 2'd2);
    s_axi_valid = 1'b0;
    chk_cnt++;
    if (m_axi_valid !== 1'b1 || m_axi_last !== 1'b0)
      $display("FAIL dual_lat_first: got valid %b last %b, required valid 1 last 0", m_axi_valid, m_axi_last);
    else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (m_axi_valid !== 1'b1 || m_axi_last !== 1'b1)
      $display("FAIL dual_b2b: got valid %b last %b, required valid 1 last 1", m_axi_valid, m_axi_last);
    else pass_cnt++;
    wait_drain();
  endtask

  task automatic test_single0();
    enables     = 4'h3;
    m_axi_ready = 1'b1;
    send_word(64'hAAAAAAAA_BBBBBBBB, 1'b1, 2'd3);
    wait_drain();
    ready_low_cnt = 0;
    for (int i = 0; i < 4; i++) send_word({32'hC0DE0000 + i, 32'hF00D0000 + i}, i[0], i[1:0]);
    chk_cnt++;
    if (ready_low_cnt == 0) $display("FAIL single_ready_throttle: got 0 low cycles, required >0");
    else pass_cnt++;
    wait_drain();
  endtask

  task automatic test_single1();
    enables     = 4'hC;
    m_axi_ready = 1'b1;
    send_word(64'h12345678_9ABCDEF0, 1'b0, 2'd1);
    wait_drain();
  endtask

  task automatic test_none();
    enables     = 4'h0;
    m_axi_ready = 1'b1;
    valid_seen  = 1'b0;
    for (int i = 0; i < 3; i++) send_word({32'hDEAD0000 + i, 32'hBEEF0000 + i}, 1'b1, 2'd0);
    repeat (8) @(posedge clk);
    #1;
    chk_cnt++;
    if (valid_seen !== 1'b0) $display("FAIL none_no_output: got valid seen %b, required 0", valid_seen);
    else pass_cnt++;
  endtask

  task automatic test_random_single0();
    logic done;
    enables = 4'h3;
    done    = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          send_word({$urandom, $urandom}, 1'($urandom_range(1, 0)), UW'($urandom_range(3, 0)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_axi_ready = 1'($urandom_range(1, 0));
          @(posedge clk);
          #1;
        end
      end
    join
    m_axi_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_enable_switch();
    enables     = 4'h3;
    m_axi_ready = 1'b0;
    send_word(64'h0A0A0A0A_0B0B0B0B, 1'b0, 2'd2);
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (m_axi_valid !== 1'b1) $display("FAIL switch_pending: got valid %b, required 1", m_axi_valid);
    else pass_cnt++;
    enables = 4'hF;
    send_word(64'h0C0C0C0C_0D0D0D0D, 1'b1, 2'd1);
    m_axi_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_pending();
    enables     = 4'h3;
    m_axi_ready = 1'b0;
    send_word(64'h01010101_02020202, 1'b1, 2'd3);
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b0;
    #1;
    chk_cnt++;
    if (m_axi_valid !== 1'b0 || m_axi_data !== 64'd0)
      $display("FAIL reset_mid_word: got valid %b data %h, required 0 and 0", m_axi_valid, m_axi_data);
    else pass_cnt++;
    exp_q.delete();
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    m_axi_ready = 1'b1;
    send_word(64'h03030303_04040404, 1'b0, 2'd2);
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_dual();
    test_single0();
    test_single1();
    test_none();
    test_random_single0();
    test_enable_switch();
    test_reset_pending();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
